window_buffer: RTL and testbench
================================

Name: window_buffer

Overview:
- Streaming line-buffer and sliding-window generator feeding the kernel accumulator stage.
- Accepts a raster-order 8-bit pixel stream and emits every fully populated SIZE x SIZE neighbourhood as a packed window matching the accumulator's `in` port layout, with its top-left image coordinate.
- Uses a valid/ready handshake on both sides; back-pressure from the accumulator stalls the pixel stream.

Parameters:
- SIZE, 3, window edge length in pixels (2..8); must equal the downstream accumulator SIZE.
- IMG_W, 16, image width in pixels (must be >= SIZE).
- IMG_H, 16, image height in pixels (must be >= SIZE).
- XW, $clog2(IMG_W), coordinate width for x (derived).
- YW, $clog2(IMG_H), coordinate width for y (derived).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- pix_in  input  8  incoming pixel, raster order, row-major.
- pix_valid  input  1  pix_in holds a valid pixel.
- pix_ready  output  1  block accepts pix_in this cycle.
- window  output  [SIZE-1:0][SIZE-1:0][7:0]  window[r][c]: r=0 top (oldest) row, c=0 leftmost (oldest) column.
- win_x  output  XW  image column of window[0][0].
- win_y  output  YW  image row of window[0][0].
- win_valid  output  1  window/win_x/win_y are valid.
- win_ready  input  1  downstream consumes window this cycle.
- frame_done  output  1  asserted with the last window of a frame (qualified by win_valid).

Behaviour:
- Reset: the decided behaviour is one clock and a synchronous, active-high reset. On rst=1 at a rising edge, clear the following:
  - col/row counters, win_valid, frame_done, win_x and win_y go to 0;
  - the window register goes to all-zero;
  - line-buffer contents need not be cleared.
- pix_ready = !(win_valid && !win_ready); combinational; 0 during the reset cycle.
- Accept: a pixel is accepted when pix_valid && pix_ready. Nothing advances otherwise; every register holds.
- Storage:
  - SIZE-1 line buffers of IMG_W x 8 bits, as a shift chain: line k holds row (cur_row-1-k).
  - On accept at column col, column col of each line buffer is read and written with the pixel from the row below.
  - A new column {line[SIZE-2][col], ..., line[0][col], pix_in} is shifted into the window register at c=SIZE-1.
  - Column c=0 is discarded.
- Counters:
  - col increments per accept and wraps IMG_W-1 -> 0.
  - row increments on col wrap and wraps IMG_H-1 -> 0 at end of frame.
  - The next frame starts immediately with no gap.
- Window generation:
  - On an accept with row >= SIZE-1 and col >= SIZE-1, the next cycle has win_valid=1, win_x=col-(SIZE-1), win_y=row-(SIZE-1).
  - Latency is exactly 1 cycle from the accepting edge.
  - Accepts at other positions update storage but leave win_valid=0 (or clear it if consumed).
  - Stale columns from the previous row are never exposed, because col >= SIZE-1 guarantees SIZE fresh columns.
- Output hold: while win_valid && !win_ready, window, win_x, win_y and frame_done hold stable and pix_ready=0.
- Consume:
  - win_valid && win_ready with a simultaneous accept that generates a window keeps win_valid=1 with the new data.
  - Otherwise win_valid falls to 0 next cycle.
  - Full throughput is 1 window/cycle.
- frame_done=1 alongside the window generated by the accept at row=IMG_H-1, col=IMG_W-1; 0 otherwise.
- Windows per frame = (IMG_W-SIZE+1)*(IMG_H-SIZE+1).
- Mid-frame reset: the partial frame is abandoned, the pending window is dropped, and the next accepted pixel is treated as (0,0).
- No combinational path from pix_in or pix_valid to any output other than via registers; pix_ready depends only on win_valid and win_ready.

Test Plan:
- Basic fill: SIZE=3, IMG_W=5, IMG_H=4; pixel = 10*row+col, stream with pix_valid=1 and win_ready=1.
  - First win_valid occurs the cycle after the 13th accept (row2, col2).
  - window = {{0,1,2},{10,11,12},{20,21,22}}, win_x=0, win_y=0.
- Window count and order: same config.
  - Exactly 6 windows, at (x,y) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - Last window = {{12,13,14},{22,23,24},{32,33,34}} with frame_done=1.
  - No window for row-wrap columns.
- Back-pressure: hold win_ready=0 for 4 cycles after the first window.
  - pix_ready=0 for those 4 cycles; the window stays stable.
  - No pixel is lost; the subsequent window at (1,0) = {{1,2,3},{11,12,13},{21,22,23}}.
- Bubbles: random pix_valid (50%) and random win_ready.
  - The window sequence and contents are identical to the no-bubble run (scoreboard against a golden model).
- Back-to-back frames: stream 2 frames of the same content without a gap.
  - The second frame yields the identical 6 windows; frame_done pulses exactly twice.
- Mid-frame reset: assert rst for 1 cycle after the 17th pixel.
  - win_valid=0 and pix_ready=0 in the reset cycle.
  - A fresh frame then produces its first window after 13 accepts with correct (0,0) content.

Source files
------------

// File: rtl/window_buffer.sv
// Streaming line buffer and sliding-window generator: turns a raster pixel stream
// into SIZE x SIZE windows tagged with their top-left coordinate.
module window_buffer #(
    parameter int SIZE  = 3,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int XW    = $clog2(IMG_W),
    parameter int YW    = $clog2(IMG_H)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      pix_in,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    output logic [SIZE-1:0][SIZE-1:0][7:0]  window,
    output logic [XW-1:0]                   win_x,
    output logic [YW-1:0]                   win_y,
    output logic                            win_valid,
    input  logic                            win_ready,
    output logic                            frame_done
);

    localparam logic [XW-1:0] COL_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] ROW_LAST  = YW'(IMG_H - 1);
    localparam logic [XW-1:0] COL_FIRST = XW'(SIZE - 1);
    localparam logic [YW-1:0] ROW_FIRST = YW'(SIZE - 1);

    logic [7:0]                     line_q [SIZE-1][IMG_W];
    logic [SIZE-1:0][SIZE-1:0][7:0] win_q, win_d;
    logic [SIZE-1:0][7:0]           newcol;
    logic [XW-1:0]                  col_q, col_d, win_x_q, win_x_d;
    logic [YW-1:0]                  row_q, row_d, win_y_q, win_y_d;
    logic                           win_valid_q, win_valid_d;
    logic                           frame_done_q, frame_done_d;
    logic                           accept, gen;

    assign pix_ready = !rst && !(win_valid_q && !win_ready);
    assign accept    = pix_valid && pix_ready;
    assign gen       = accept && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);

    // Line k holds row (cur_row-1-k); window row 0 is the oldest line.
    always_comb begin
        for (int unsigned r = 0; r < SIZE - 1; r++) begin
            newcol[r] = line_q[SIZE-2-r][col_q];
        end
        newcol[SIZE-1] = pix_in;
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_x_d      = win_x_q;
        win_y_d      = win_y_q;
        win_valid_d  = win_valid_q;
        frame_done_d = frame_done_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            for (int unsigned r = 0; r < SIZE; r++) begin
                for (int unsigned c = 0; c < SIZE - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][SIZE-1] = newcol[r];
            end
            win_valid_d  = gen;
            frame_done_d = gen && (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (gen) begin
                win_x_d = col_q - COL_FIRST;
                win_y_d = row_q - ROW_FIRST;
            end
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            line_q[0][col_q] <= pix_in;
            for (int unsigned k = 1; k < SIZE - 1; k++) begin
                line_q[k][col_q] <= line_q[k-1][col_q];
            end
        end
    end

    assign window     = win_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_buffer.sv
// Directed bench for window_buffer: 5x4 image, pixel = 10*row+col, 3x3 windows.
module tb_window_buffer;
    localparam int SIZE  = 3;
    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int NWX   = IMG_W - SIZE + 1;
    localparam int NWIN  = NWX * (IMG_H - SIZE + 1);
    localparam int NPIX  = IMG_W * IMG_H;

    typedef logic [SIZE-1:0][SIZE-1:0][7:0] win_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    pix_in;
    logic          pix_valid;
    logic          pix_ready;
    win_t          window;
    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;
    logic          win_valid;
    logic          win_ready;
    logic          frame_done;

    int checks   = 0;
    int failures = 0;

    window_buffer #(.SIZE(SIZE), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .window(window), .win_x(win_x), .win_y(win_y),
        .win_valid(win_valid), .win_ready(win_ready), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix_val(int p);
        int q = p % NPIX;
        return 8'(10 * (q / IMG_W) + (q % IMG_W));
    endfunction

    function automatic win_t exp_win(int k);
        win_t w;
        int x = k % NWX;
        int y = k / NWX;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                w[r][c] = 8'(10 * (y + r) + x + c);
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1; pix_valid = 1'b0; win_ready = 1'b1; pix_in = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_valid = 1'b1; win_ready = 1'b0; pix_in = 8'hAA;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b0) begin failures++; $display("FAIL reset_pix_ready got=%b want=0", pix_ready); end
        @(posedge clk); #1;
        rst = 1'b0; pix_valid = 1'b0;
        checks++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
            failures++; $display("FAIL reset_flags got win_valid=%b frame_done=%b want 0 0", win_valid, frame_done);
        end
        checks++;
        if (win_x !== '0 || win_y !== '0) begin
            failures++; $display("FAIL reset_coord got x=%0d y=%0d want 0 0", win_x, win_y);
        end
        checks++;
        if (window !== '0) begin failures++; $display("FAIL reset_window got=%h want=0", window); end
        #1;
        checks++;
        if (pix_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b want=1", pix_ready); end
    endtask

    task automatic test_basic_fill();
        int early = 0;
        do_reset();
        pix_valid = 1'b1; win_ready = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            pix_in = pix_val(i - 1);
            @(posedge clk); #1;
            if (i < 13 && win_valid !== 1'b0) early++;
        end
        pix_valid = 1'b0;
        checks++;
        if (early != 0) begin failures++; $display("FAIL fill_early got=%0d early windows want=0", early); end
        checks++;
        if (win_valid !== 1'b1) begin failures++; $display("FAIL fill_valid got=%b want=1", win_valid); end
        checks++;
        if (window !== exp_win(0)) begin failures++; $display("FAIL fill_window got=%h want=%h", window, exp_win(0)); end
        checks++;
        if (win_x !== '0 || win_y !== '0) begin
            failures++; $display("FAIL fill_coord got x=%0d y=%0d want 0 0", win_x, win_y);
        end
    endtask

    task automatic test_count_order();
        int nwin = 0;
        do_reset();
        win_ready = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            pix_in = pix_val(i); pix_valid = 1'b1;
            @(posedge clk); #1;
            if (win_valid === 1'b1) begin
                checks++;
                if (nwin >= NWIN || window !== exp_win(nwin) || win_x !== XW'(nwin % NWX) ||
                    win_y !== YW'(nwin / NWX) || frame_done !== (nwin == NWIN - 1)) begin
                    failures++;
                    $display("FAIL order_win%0d got=%h x=%0d y=%0d fd=%b want=%h x=%0d y=%0d fd=%b",
                             nwin, window, win_x, win_y, frame_done, exp_win(nwin), nwin % NWX,
                             nwin / NWX, nwin == NWIN - 1);
                end
                nwin++;
            end
        end
        pix_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (win_valid !== 1'b0) begin failures++; $display("FAIL order_drain got=%b want=0", win_valid); end
        checks++;
        if (nwin != NWIN) begin failures++; $display("FAIL order_count got=%0d want=%0d", nwin, NWIN); end
    endtask

    task automatic test_back_pressure();
        win_t hold;
        int bad = 0;
        do_reset();
        pix_valid = 1'b1; win_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            pix_in = pix_val(i);
            @(posedge clk); #1;
        end
        hold = window;
        win_ready = 1'b0; pix_in = pix_val(13);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (pix_ready !== 1'b0) bad++;
            @(posedge clk); #1;
            if (win_valid !== 1'b1 || window !== hold || win_x !== '0 || win_y !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL bp_hold got=%0d violations want=0", bad); end
        win_ready = 1'b1;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        checks++;
        if (win_valid !== 1'b1 || window !== exp_win(1) || win_x !== XW'(1) || win_y !== '0) begin
            failures++;
            $display("FAIL bp_next got=%h v=%b x=%0d want=%h v=1 x=1", window, win_valid, win_x, exp_win(1));
        end
    endtask

    task automatic test_bubbles();
        int   nwin = 0, p = 0, bad = 0, cyc = 0;
        logic acc, held = 1'b0;
        win_t hw;
        logic [XW-1:0] hx;
        do_reset();
        while (nwin < NWIN && cyc < 3000) begin
            pix_valid = (p < NPIX) && ($urandom_range(0, 1) == 1);
            pix_in    = pix_val(p);
            win_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (pix_ready !== !(win_valid && !win_ready)) bad++;
            if (held && (win_valid !== 1'b1 || window !== hw || win_x !== hx)) bad++;
            acc = pix_valid && pix_ready;
            if (win_valid && win_ready) begin
                checks++;
                if (window !== exp_win(nwin) || win_x !== XW'(nwin % NWX) || win_y !== YW'(nwin / NWX) ||
                    frame_done !== (nwin == NWIN - 1)) begin
                    failures++;
                    $display("FAIL bubble_win%0d got=%h x=%0d y=%0d want=%h", nwin, window, win_x,
                             win_y, exp_win(nwin));
                end
                nwin++;
            end
            held = win_valid && !win_ready;
            hw = window; hx = win_x;
            @(posedge clk); #1;
            if (acc) p++;
            cyc++;
        end
        pix_valid = 1'b0; win_ready = 1'b1;
        checks++;
        if (nwin != NWIN) begin failures++; $display("FAIL bubble_count got=%0d want=%0d", nwin, NWIN); end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL bubble_handshake got=%0d violations want=0", bad); end
    endtask

    task automatic test_back_to_back();
        int nwin = 0, nfd = 0;
        do_reset();
        win_ready = 1'b1;
        for (int i = 0; i < 2 * NPIX; i++) begin
            pix_in = pix_val(i); pix_valid = 1'b1;
            @(posedge clk); #1;
            if (win_valid === 1'b1) begin
                checks++;
                if (window !== exp_win(nwin % NWIN) || win_x !== XW'((nwin % NWIN) % NWX) ||
                    win_y !== YW'((nwin % NWIN) / NWX) || frame_done !== (nwin % NWIN == NWIN - 1)) begin
                    failures++;
                    $display("FAIL b2b_win%0d got=%h fd=%b want=%h", nwin, window, frame_done,
                             exp_win(nwin % NWIN));
                end
                if (frame_done === 1'b1) nfd++;
                nwin++;
            end
        end
        pix_valid = 1'b0;
        checks++;
        if (nwin != 2 * NWIN) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", nwin, 2 * NWIN); end
        checks++;
        if (nfd != 2) begin failures++; $display("FAIL b2b_frame_done got=%0d want=2", nfd); end
    endtask

    task automatic test_mid_reset();
        int early = 0;
        do_reset();
        win_ready = 1'b1; pix_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            pix_in = pix_val(i);
            @(posedge clk); #1;
        end
        rst = 1'b1; pix_in = pix_val(17);
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b want=0", pix_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (win_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", win_valid); end
        for (int i = 1; i <= 13; i++) begin
            pix_in = pix_val(i - 1);
            @(posedge clk); #1;
            if (i < 13 && win_valid !== 1'b0) early++;
        end
        pix_valid = 1'b0;
        checks++;
        if (early != 0 || win_valid !== 1'b1 || window !== exp_win(0) || win_x !== '0 || win_y !== '0) begin
            failures++;
            $display("FAIL midrst_first got=%h v=%b early=%0d x=%0d y=%0d want=%h v=1 early=0 x=0 y=0",
                     window, win_valid, early, win_x, win_y, exp_win(0));
        end
    endtask

    initial begin
        rst = 1'b1; pix_valid = 1'b0; win_ready = 1'b1; pix_in = '0;
        test_reset();
        test_basic_fill();
        test_count_order();
        test_back_pressure();
        test_bubbles();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
